// File: rtl/armleocpu_operand_fetch.sv
// Operand-fetch stage between decode and execute: drives both regfile read lanes and holds the operands.
// Define ARMLEOCPU_OPERAND_FETCH_BYPASS_EN to forward write-back data into in-flight and held operands.
module armleocpu_operand_fetch #(
   parameter int ELEMENTS_W = 5,
   parameter int WIDTH      = 32,
   parameter int TAG_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,

   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ELEMENTS_W-1:0] in_rs1_addr,
   input  logic [ELEMENTS_W-1:0] in_rs2_addr,
   input  logic [TAG_W-1:0]      in_tag,

   output logic [ELEMENTS_W-1:0] rf_readaddress1,
   output logic                  rf_read1,
   input  logic [WIDTH-1:0]      rf_readdata1,
   output logic [ELEMENTS_W-1:0] rf_readaddress2,
   output logic                  rf_read2,
   input  logic [WIDTH-1:0]      rf_readdata2,

   input  logic                  wb_write,
   input  logic [ELEMENTS_W-1:0] wb_addr,
   input  logic [WIDTH-1:0]      wb_data,

   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_rs1_data,
   output logic [WIDTH-1:0]      out_rs2_data,
   output logic [TAG_W-1:0]      out_tag,

   output logic [1:0]            dbg_state
);

   // Both handshakes: a transfer happens on a cycle where valid && ready; valid never depends on ready.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ELEMENTS_W-1:0]   rs1_addr_q, rs2_addr_q;
   logic [TAG_W-1:0]        tag_q;
   logic [WIDTH-1:0]        op1_q, op2_q;
   logic [WIDTH-1:0]        rd1_val, rd2_val;
   logic                    accept;

   assign in_ready        = !flush && (state_q == IDLE || (state_q == FULL && out_ready));
   assign accept          = in_valid && in_ready;
   assign rf_read1        = accept;
   assign rf_read2        = accept;
   assign rf_readaddress1 = in_rs1_addr;
   assign rf_readaddress2 = in_rs2_addr;

   assign out_valid    = (state_q == FULL);
   assign out_rs1_data = op1_q;
   assign out_rs2_data = op2_q;
   assign out_tag      = tag_q;
   assign dbg_state    = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = READ;
         READ:    state_d = FULL;
         FULL:    if (out_ready) state_d = accept ? READ : IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

`ifdef ARMLEOCPU_OPERAND_FETCH_BYPASS_EN
   logic             pend1_q, pend2_q;
   logic [WIDTH-1:0] pend_data1_q, pend_data2_q;
   logic             hold_upd1, hold_upd2;

   // The lanes return pre-write data when read and write collide, so remember the write seen at accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend1_q      <= 1'b0;
         pend2_q      <= 1'b0;
         pend_data1_q <= '0;
         pend_data2_q <= '0;
      end else if (flush) begin
         pend1_q <= 1'b0;
         pend2_q <= 1'b0;
      end else if (accept) begin
         pend1_q      <= wb_write && (wb_addr == in_rs1_addr) && (in_rs1_addr != '0);
         pend2_q      <= wb_write && (wb_addr == in_rs2_addr) && (in_rs2_addr != '0);
         pend_data1_q <= wb_data;
         pend_data2_q <= wb_data;
      end else if (state_q == READ) begin
         pend1_q <= 1'b0;
         pend2_q <= 1'b0;
      end
   end

   always_comb begin
      rd1_val = rf_readdata1;
      rd2_val = rf_readdata2;
      if (wb_write && wb_addr == rs1_addr_q) rd1_val = wb_data;
      else if (pend1_q)                      rd1_val = pend_data1_q;
      if (wb_write && wb_addr == rs2_addr_q) rd2_val = wb_data;
      else if (pend2_q)                      rd2_val = pend_data2_q;
      if (rs1_addr_q == '0) rd1_val = '0;
      if (rs2_addr_q == '0) rd2_val = '0;
   end

   assign hold_upd1 = (state_q == FULL) && !out_ready && wb_write &&
                      (wb_addr == rs1_addr_q) && (rs1_addr_q != '0);
   assign hold_upd2 = (state_q == FULL) && !out_ready && wb_write &&
                      (wb_addr == rs2_addr_q) && (rs2_addr_q != '0);
`else
   logic unused_wb;

   assign unused_wb = ^{wb_write, wb_addr, wb_data};

   always_comb begin
      rd1_val = (rs1_addr_q == '0) ? '0 : rf_readdata1;
      rd2_val = (rs2_addr_q == '0) ? '0 : rf_readdata2;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         tag_q      <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rs1_addr_q <= in_rs1_addr;
            rs2_addr_q <= in_rs2_addr;
            tag_q      <= in_tag;
         end
         if (state_q == READ && !flush) begin
            op1_q <= rd1_val;
            op2_q <= rd2_val;
         end
`ifdef ARMLEOCPU_OPERAND_FETCH_BYPASS_EN
         else begin
            if (hold_upd1) op1_q <= wb_data;
            if (hold_upd2) op2_q <= wb_data;
         end
`endif
      end
   end

endmodule

// File: tb/tb_armleocpu_operand_fetch.sv
// Bench for armleocpu_operand_fetch: directed plan steps followed by random traffic against an op-queue model.
module tb_armleocpu_operand_fetch;

   logic        clk = 1'b0;
   logic        rst_n, flush;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs1_addr, in_rs2_addr;
   logic [31:0] in_tag;
   logic [4:0]  rf_readaddress1, rf_readaddress2;
   logic        rf_read1, rf_read2;
   logic [31:0] rf_readdata1, rf_readdata2;
   logic        wb_write;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid, out_ready;
   logic [31:0] out_rs1_data, out_rs2_data, out_tag;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   armleocpu_operand_fetch #(.ELEMENTS_W(5), .WIDTH(32), .TAG_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_tag(in_tag),
      .rf_readaddress1(rf_readaddress1), .rf_read1(rf_read1), .rf_readdata1(rf_readdata1),
      .rf_readaddress2(rf_readaddress2), .rf_read2(rf_read2), .rf_readdata2(rf_readdata2),
      .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_tag(out_tag),
      .dbg_state(dbg_state)
   );

   // Register file lanes: 1-cycle read latency, a colliding read returns the old contents.
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (rf_read1) rf_readdata1 <= mem[rf_readaddress1];
      if (rf_read2) rf_readdata2 <= mem[rf_readaddress2];
      if (wb_write) mem[wb_addr] <= wb_data;
   end

   // Model: the stage holds at most one op, visible two cycles after accept.
   typedef struct {
      logic [4:0]  a1, a2;
      logic [31:0] tag, s1, s2;
      int          vis;
   } op_t;

   op_t  exp_q[$];
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   logic zero_out = 1'b1;
   logic last_ir;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_op(input logic [4:0] a, input logic [31:0] snap);
      if (a == 5'd0) return 32'd0;
`ifdef ARMLEOCPU_OPERAND_FETCH_BYPASS_EN
      return mem[a];
`else
      return snap;
`endif
   endfunction

   task automatic step(input logic r, input logic f, input logic iv,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] tg,
                       input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ordy);
      logic exp_ov, exp_ir, acc;
      op_t  op;
      rst_n = r; flush = f; in_valid = iv; in_rs1_addr = a1; in_rs2_addr = a2; in_tag = tg;
      wb_write = ww; wb_addr = wa; wb_data = wd; out_ready = ordy;
      #1;
      last_ir = in_ready;
      exp_ov = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
      if (r) begin
         exp_ir = !f && (exp_q.size() == 0 || (exp_ov && ordy));
         acc = iv && exp_ir;
         chk("in_ready", in_ready, exp_ir);
         chk("rf_read1", rf_read1, acc);
         chk("rf_read2", rf_read2, acc);
         chk("rf_addr1", rf_readaddress1, a1);
         chk("rf_addr2", rf_readaddress2, a2);
         chk("out_valid", out_valid, exp_ov);
         if (exp_ov) begin
            chk("out_rs1", out_rs1_data, exp_op(exp_q[0].a1, exp_q[0].s1));
            chk("out_rs2", out_rs2_data, exp_op(exp_q[0].a2, exp_q[0].s2));
            chk("out_tag", out_tag, exp_q[0].tag);
         end else if (zero_out) begin
            chk("rst_rs1", out_rs1_data, 32'd0);
            chk("rst_rs2", out_rs2_data, 32'd0);
            chk("rst_tag", out_tag, 32'd0);
         end
         if (f) exp_q.delete();
         else begin
            if (exp_ov && ordy) void'(exp_q.pop_front());
            if (acc) begin
               op.a1 = a1; op.a2 = a2; op.tag = tg;
               op.s1 = mem[a1]; op.s2 = mem[a2]; op.vis = cyc + 2;
               exp_q.push_back(op);
               zero_out = 1'b0;
            end
         end
      end else begin
         exp_q.delete();
         zero_out = 1'b1;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      step(1, 0, 0, 0, 0, 0, 1, a, d, 1);
   endtask

   initial begin
      rst_n = 0; flush = 0; in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_tag = 0;
      wb_write = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
      @(negedge clk);

      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) wr(i[4:0], $urandom);
      wr(5, 32'h11); wr(6, 32'h22); wr(7, 32'h1); wr(9, 32'h55); wr(0, 32'hFFFF_FFFF);

      // Basic read with tag
      step(1, 0, 1, 5, 6, 32'hCAFE_0001, 0, 0, 0, 1);
      idle(0);
      chk("plan_valid", out_valid, 1'b1);
      chk("plan_rs1", out_rs1_data, 32'h11);
      chk("plan_rs2", out_rs2_data, 32'h22);
      chk("plan_tag", out_tag, 32'hCAFE_0001);
      idle(1);

      // x0 forced to zero even though the lane holds all-ones
      step(1, 0, 1, 0, 0, 32'h2, 0, 0, 0, 1);
      idle(0);
      chk("x0_rs1", out_rs1_data, 32'h0);
      chk("x0_rs2", out_rs2_data, 32'h0);
      idle(1);

      // Write-back colliding with the accept cycle
      step(1, 0, 1, 7, 6, 32'h3, 1, 7, 32'hA5A5_A5A5, 1);
      idle(0);
`ifdef ARMLEOCPU_OPERAND_FETCH_BYPASS_EN
      chk("pend_rs1", out_rs1_data, 32'hA5A5_A5A5);
`else
      chk("pend_rs1", out_rs1_data, 32'h1);
`endif
      idle(1);

      // Write-back to a held operand
      step(1, 0, 1, 1, 9, 32'h4, 0, 0, 0, 0);
      idle(0);
      step(1, 0, 0, 0, 0, 0, 1, 9, 32'h1234, 0);
      chk("held_valid", out_valid, 1'b1);
`ifdef ARMLEOCPU_OPERAND_FETCH_BYPASS_EN
      chk("held_rs2", out_rs2_data, 32'h1234);
`else
      chk("held_rs2", out_rs2_data, 32'h55);
`endif
      idle(1);

      // Back-to-back issue: in_ready alternates 1,0,1,0
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom, 0, 0, 0, 1);
         chk("b2b_ready", last_ir, (i % 2) == 0);
      end
      idle(1); idle(1);

      // Flush during READ
      step(1, 0, 1, 5, 6, 32'h5, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      chk("flush_valid", out_valid, 1'b0);
      idle(1);

      // Reset while FULL
      step(1, 0, 1, 5, 6, 32'h6, 0, 0, 0, 0);
      idle(0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_out1", out_rs1_data, 32'h0);

      // Random traffic with small address range to force hazards
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom,
              $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
              $urandom_range(0, 2) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
